instr_mem_loadable: RTL and testbench
=====================================

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 SHALL have parameter WORD_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of instruction words (2..4096).
REQ-003 SHALL have parameter ADDR_W, default 32, byte fetch-address width.
REQ-004 SHALL have parameter NOP_WORD, default 32'hE1A00000, word returned on reset, flush and fault.
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous reset, active low.
REQ-006 SHALL have the following load ports: load_start  in  1  (re)start program load; load_valid  in  1  load_data is valid; load_data  in  WORD_W  word to write; load_last  in  1  marks final word; load_ready  out  1  block is accepting load words; load_count  out  clog2(DEPTH+1)  words loaded.
REQ-007 SHALL have the following fetch ports: mem_ready  out  1  program loaded, fetches allowed; fetch_en  in  1  fetch request; fetch_addr  in  ADDR_W  byte address; hold  in  1  pipeline stall; flush  in  1  kill output.
REQ-008 SHALL have the following outputs: instruction  out  WORD_W  fetched word; instr_valid  out  1  instruction is valid; addr_fault  out  1  misaligned or unloaded address.

Function
REQ-009 SHALL implement FSM states IDLE, LOADING and READY; load_ready=1 only in LOADING; mem_ready=1 only in READY.
REQ-010 SHALL move from any state to LOADING on load_start=1, clearing the write pointer and load_count to 0 and instr_valid to 0.
REQ-011 SHALL, in LOADING with load_valid=1 and load_start=0, write load_data to mem[pointer] and increment pointer and load_count at the same edge.
REQ-012 SHALL move LOADING->READY on the edge that accepts a word with load_last=1, or on the edge that writes word DEPTH-1 (full), whichever comes first.
REQ-013 SHALL ignore load_valid in IDLE and READY; memory contents SHALL be unchanged.
REQ-014 SHALL give load_start priority over a simultaneous load_valid; the word presented on that cycle SHALL be discarded.
REQ-015 SHALL present a fetch with 1-cycle latency: fetch_en=1 in READY with hold=0 and flush=0 at edge N -> instruction/instr_valid/addr_fault updated at edge N.
REQ-016 SHALL use index = fetch_addr >> 2.
REQ-017 SHALL set addr_fault=1 and instruction=NOP_WORD, with instr_valid=1, if fetch_addr[1:0]!=0 or index >= load_count.
REQ-018 SHALL otherwise set instruction=mem[index] and addr_fault=0.
REQ-019 SHALL set instr_valid=0 and addr_fault=0 and hold instruction when fetch_en=0 with hold=0.
REQ-020 SHALL set instr_valid=0 when fetch_en=1 outside READY.
REQ-021 SHALL, when hold=1, keep instruction, instr_valid and addr_fault unchanged and drop any fetch.
REQ-022 SHALL apply flush=1 above hold and fetch: next edge instruction=NOP_WORD, instr_valid=0, addr_fault=0.
REQ-023 SHALL never let a fetch read a word being written on the same edge, because fetches are only served in READY.
REQ-024 SHALL leave memory array contents undefined until written; reads beyond load_count are covered by REQ-017.

Reset
REQ-025 SHALL, on rst_n=0 at a clk edge, set state=IDLE, pointer=0, load_count=0, instruction=NOP_WORD, instr_valid=0, addr_fault=0, load_ready=0, mem_ready=0.
REQ-026 SHALL let reset override all inputs, including a load in progress.
REQ-027 SHALL NOT clear the memory array on reset.

Verification
REQ-028 Bench SHALL cover: reset, then fetch_en=1 addr 0x0 -> instr_valid=0, mem_ready=0, instruction=32'hE1A00000.
REQ-029 Bench SHALL cover: load E3A00014, E3A01A01, E3A02103 (last on 3rd), then fetch 0x8 -> load_count=3, mem_ready=1, next cycle instruction=E3A02103, instr_valid=1, addr_fault=0.
REQ-030 Bench SHALL cover: after REQ-029, fetch 0xC -> NOP_WORD, addr_fault=1, instr_valid=1; then fetch 0x6 -> addr_fault=1.
REQ-031 Bench SHALL cover: fetch 0x4, then hold=1 for 3 cycles with fetch 0x0 -> instruction stays E3A01A01; then flush=1 with hold=1 -> instr_valid=0, instruction=NOP_WORD.
REQ-032 Bench SHALL cover: DEPTH=64, load 64 words with load_last=0 -> READY after the 64th word, load_count=64, 65th load_valid ignored, fetch 0xFC returns the 64th word.
REQ-033 Bench SHALL cover: rst_n=0 after 2 words of a load -> IDLE, load_count=0; load_start mid-READY -> LOADING, instr_valid=0, load_count=0.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// instr_mem_loadable
//
// Instruction memory that is filled by a streaming loader and then serves
// word fetches to a CPU front end. A small FSM (IDLE -> LOADING -> READY)
// controls the phases. Loading ends on a word flagged load_last or when the
// array is full. Fetches are served only in READY, so a read never sees a
// word that is being written on the same edge. A fetch is answered one cycle
// later with the addressed word, or with NOP_WORD plus addr_fault when the
// address is misaligned or points past the loaded program.
//
// Ports
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   load_start    (re)start a program load, restarting from word 0
//   load_valid    load_data holds a word to write (only used in LOADING)
//   load_data     word to write at the current load pointer
//   load_last     marks the final word of the program
//   load_ready    high in LOADING only
//   load_count    number of words loaded so far
//   mem_ready     high in READY only; fetches are served
//   fetch_en      fetch request
//   fetch_addr    byte address; word index = fetch_addr >> 2
//   hold          pipeline stall: outputs frozen, fetch dropped
//   flush         kill output (takes priority over hold and fetch)
//   instruction   fetched word (NOP_WORD after reset, flush or fault)
//   instr_valid   instruction is valid
//   addr_fault    misaligned or unloaded fetch address
// -----------------------------------------------------------------------------
module instr_mem_loadable #(
  parameter int              WORD_W   = 32,
  parameter int              DEPTH    = 64,
  parameter int              ADDR_W   = 32,
  parameter logic [WORD_W-1:0] NOP_WORD = 32'hE1A00000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // load side
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [WORD_W-1:0]            load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic [$clog2(DEPTH+1)-1:0]   load_count,
  // fetch side
  output logic                         mem_ready,
  input  logic                         fetch_en,
  input  logic [ADDR_W-1:0]            fetch_addr,
  input  logic                         hold,
  input  logic                         flush,
  output logic [WORD_W-1:0]            instruction,
  output logic                         instr_valid,
  output logic                         addr_fault
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOADING,
    S_READY
  } state_e;

  state_e              state_q, state_d;
  // The write pointer always equals the number of words loaded, so a single
  // counter serves as both.
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WORD_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                fault_q, fault_d;

  logic [WORD_W-1:0]   mem [DEPTH];
  logic                wr_en;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_idx;
  logic [ADDR_W-1:0]   idx_w;
  logic [ADDR_W-1:0]   cnt_w;
  logic                bad_addr;
  logic [WORD_W-1:0]   rd_word;

  assign wr_ptr = count_q[PTR_W-1:0];
  assign rd_idx = fetch_addr[PTR_W+1:2];
  assign idx_w  = fetch_addr >> 2;
  assign cnt_w  = ADDR_W'(count_q);
  // Compare the full word index, not just the bits that address the array,
  // so large addresses that would alias into the array still fault.
  assign bad_addr = (fetch_addr[1:0] != 2'b00) || (idx_w >= cnt_w);
  assign rd_word  = mem[rd_idx];

  // Load FSM: load_start wins over everything, discarding a coincident word.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (load_start) begin
      state_d = S_LOADING;
      count_d = '0;
    end else if (state_q == S_LOADING && load_valid) begin
      wr_en   = 1'b1;
      count_d = count_q + CNT_W'(1);
      if (load_last || count_q == CNT_W'(DEPTH - 1)) begin
        state_d = S_READY;
      end
    end
  end

  // Fetch output path. Priority: flush, load restart, hold, fetch, idle.
  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (load_start) begin
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (hold) begin
      // outputs frozen, any fetch this cycle is dropped
    end else if (fetch_en && state_q == S_READY) begin
      valid_d = 1'b1;
      if (bad_addr) begin
        instr_d = NOP_WORD;
        fault_d = 1'b1;
      end else begin
        instr_d = rd_word;
        fault_d = 1'b0;
      end
    end else begin
      // no fetch, or a fetch before the program is loaded
      valid_d = 1'b0;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // NOTE: the array has no reset; unwritten words are never returned because
  // any index at or beyond load_count faults. Reset still blocks a write.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      mem[wr_ptr] <= load_data;
    end
  end

  assign load_ready  = (state_q == S_LOADING);
  assign mem_ready   = (state_q == S_READY);
  assign load_count  = count_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign addr_fault  = fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loadable
//
// Directed bench for instr_mem_loadable (default parameters). A table of
// one-cycle vectors covers reset, load, fetch, fault, hold, flush, restart and
// reset-during-load; a hand-written sequence covers the full-array load.
// -----------------------------------------------------------------------------
module tb_instr_mem_loadable;

  localparam logic [31:0] NOP = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_valid, load_last;
  logic [31:0] load_data;
  logic        load_ready;
  logic [6:0]  load_count;
  logic        mem_ready;
  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        hold, flush;
  logic [31:0] instruction;
  logic        instr_valid, addr_fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_mem_loadable dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_count  (load_count),
    .mem_ready   (mem_ready),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .hold        (hold),
    .flush       (flush),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .addr_fault  (addr_fault)
  );

  typedef struct {
    string       name;
    // inputs applied for one clock
    logic        rst_n;
    logic        ls;
    logic        lv;
    logic [31:0] ld;
    logic        llast;
    logic        fe;
    logic [31:0] fa;
    logic        hold;
    logic        flush;
    // expected outputs after that clock edge
    logic        lr;
    logic        mr;
    logic [6:0]  cnt;
    logic [31:0] ins;
    logic        v;
    logic        f;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic ls, input logic lv, input logic [31:0] ld,
                       input logic llast, input logic fe, input logic [31:0] fa,
                       input logic h, input logic fl);
    rst_n = r; load_start = ls; load_valid = lv; load_data = ld; load_last = llast;
    fetch_en = fe; fetch_addr = fa; hold = h; flush = fl;
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string n, input logic lr, input logic mr, input logic [6:0] cnt,
                           input logic [31:0] ins, input logic v, input logic f);
    check({n, ".load_ready"},  32'(load_ready),  32'(lr));
    check({n, ".mem_ready"},   32'(mem_ready),   32'(mr));
    check({n, ".load_count"},  32'(load_count),  32'(cnt));
    check({n, ".instruction"}, instruction,      ins);
    check({n, ".instr_valid"}, 32'(instr_valid), 32'(v));
    check({n, ".addr_fault"},  32'(addr_fault),  32'(f));
  endtask

  initial begin
    //                 name         rst ls lv data          last fe addr    hold flush  lr mr cnt ins           v  f
    vecs.push_back('{"reset",        0, 0, 0, 32'h0,        0,  0, 32'h0,  0,   0,     0, 0, 0, NOP,          0, 0});
    vecs.push_back('{"idle_fetch",   1, 0, 0, 32'h0,        0,  1, 32'h0,  0,   0,     0, 0, 0, NOP,          0, 0});
    vecs.push_back('{"start",        1, 1, 0, 32'h0,        0,  0, 32'h0,  0,   0,     1, 0, 0, NOP,          0, 0});
    vecs.push_back('{"load0",        1, 0, 1, 32'hE3A00014, 0,  0, 32'h0,  0,   0,     1, 0, 1, NOP,          0, 0});
    vecs.push_back('{"load1",        1, 0, 1, 32'hE3A01A01, 0,  0, 32'h0,  0,   0,     1, 0, 2, NOP,          0, 0});
    vecs.push_back('{"load2_last",   1, 0, 1, 32'hE3A02103, 1,  0, 32'h0,  0,   0,     0, 1, 3, NOP,          0, 0});
    vecs.push_back('{"fetch_8",      1, 0, 0, 32'h0,        0,  1, 32'h8,  0,   0,     0, 1, 3, 32'hE3A02103, 1, 0});
    vecs.push_back('{"fetch_C",      1, 0, 0, 32'h0,        0,  1, 32'hC,  0,   0,     0, 1, 3, NOP,          1, 1});
    vecs.push_back('{"fetch_6",      1, 0, 0, 32'h0,        0,  1, 32'h6,  0,   0,     0, 1, 3, NOP,          1, 1});
    vecs.push_back('{"no_fetch",     1, 0, 0, 32'h0,        0,  0, 32'h0,  0,   0,     0, 1, 3, NOP,          0, 0});
    vecs.push_back('{"fetch_4",      1, 0, 0, 32'h0,        0,  1, 32'h4,  0,   0,     0, 1, 3, 32'hE3A01A01, 1, 0});
    vecs.push_back('{"hold1",        1, 0, 0, 32'h0,        0,  1, 32'h0,  1,   0,     0, 1, 3, 32'hE3A01A01, 1, 0});
    vecs.push_back('{"hold2",        1, 0, 0, 32'h0,        0,  1, 32'h0,  1,   0,     0, 1, 3, 32'hE3A01A01, 1, 0});
    vecs.push_back('{"hold3",        1, 0, 0, 32'h0,        0,  1, 32'h0,  1,   0,     0, 1, 3, 32'hE3A01A01, 1, 0});
    vecs.push_back('{"flush_hold",   1, 0, 0, 32'h0,        0,  1, 32'h0,  1,   1,     0, 1, 3, NOP,          0, 0});
    vecs.push_back('{"ready_lv_ign", 1, 0, 1, 32'hDEADBEEF, 0,  1, 32'h0,  0,   0,     0, 1, 3, 32'hE3A00014, 1, 0});
    vecs.push_back('{"restart",      1, 1, 1, 32'h11111111, 0,  1, 32'h0,  0,   0,     1, 0, 0, 32'hE3A00014, 0, 0});
    vecs.push_back('{"rl0",          1, 0, 1, 32'h22222222, 0,  0, 32'h0,  0,   0,     1, 0, 1, 32'hE3A00014, 0, 0});
    vecs.push_back('{"rl1_last",     1, 0, 1, 32'h33333333, 1,  0, 32'h0,  0,   0,     0, 1, 2, 32'hE3A00014, 0, 0});
    vecs.push_back('{"rfetch_0",     1, 0, 0, 32'h0,        0,  1, 32'h0,  0,   0,     0, 1, 2, 32'h22222222, 1, 0});
    vecs.push_back('{"rfetch_8",     1, 0, 0, 32'h0,        0,  1, 32'h8,  0,   0,     0, 1, 2, NOP,          1, 1});
    vecs.push_back('{"restart2",     1, 1, 0, 32'h0,        0,  0, 32'h0,  0,   0,     1, 0, 0, NOP,          0, 0});
    vecs.push_back('{"ml0",          1, 0, 1, 32'h66666666, 0,  0, 32'h0,  0,   0,     1, 0, 1, NOP,          0, 0});
    vecs.push_back('{"ml1",          1, 0, 1, 32'h77777777, 0,  0, 32'h0,  0,   0,     1, 0, 2, NOP,          0, 0});
    vecs.push_back('{"rst_mid_load", 0, 0, 1, 32'h88888888, 0,  1, 32'h0,  0,   0,     0, 0, 0, NOP,          0, 0});
    vecs.push_back('{"idle_lv_ign",  1, 0, 1, 32'h99999999, 0,  0, 32'h0,  0,   0,     0, 0, 0, NOP,          0, 0});
    vecs.push_back('{"idle_fetch2",  1, 0, 0, 32'h0,        0,  1, 32'h0,  0,   0,     0, 0, 0, NOP,          0, 0});

    drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].ls, vecs[i].lv, vecs[i].ld, vecs[i].llast,
            vecs[i].fe, vecs[i].fa, vecs[i].hold, vecs[i].flush);
      step();
      check_all(vecs[i].name, vecs[i].lr, vecs[i].mr, vecs[i].cnt, vecs[i].ins,
                vecs[i].v, vecs[i].f);
    end

    // Full-array load: 64 words, load_last never set.
    drive(1, 1, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();
    check("full.start_load_ready", 32'(load_ready), 32'd1);
    for (int i = 0; i < 64; i++) begin
      drive(1, 0, 1, 32'hA5000000 + 32'(i), 0, 0, 32'h0, 0, 0);
      step();
      check($sformatf("full.count_%0d", i), 32'(load_count), 32'(i + 1));
      if (i == 62) check("full.still_loading", 32'(load_ready), 32'd1);
    end
    check("full.mem_ready", 32'(mem_ready), 32'd1);
    check("full.load_ready", 32'(load_ready), 32'd0);

    // 65th word is ignored in READY.
    drive(1, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0, 0, 0);
    step();
    check("full.extra_count", 32'(load_count), 32'd64);
    check("full.extra_ready", 32'(mem_ready), 32'd1);

    drive(1, 0, 0, 32'h0, 0, 1, 32'hFC, 0, 0);
    step();
    check("full.fetch_FC", instruction, 32'hA500003F);
    check("full.fetch_FC_valid", 32'(instr_valid), 32'd1);
    check("full.fetch_FC_fault", 32'(addr_fault), 32'd0);

    drive(1, 0, 0, 32'h0, 0, 1, 32'h0, 0, 0);
    step();
    check("full.fetch_0", instruction, 32'hA5000000);

    drive(1, 0, 0, 32'h0, 0, 1, 32'h100, 0, 0);
    step();
    check("full.fetch_100", instruction, NOP);
    check("full.fetch_100_fault", 32'(addr_fault), 32'd1);

    drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
